pooling_ctrl: RTL
=================

// Module: pooling_ctrl
// PURPOSE
//  Sequencer driving the pooling datapath's 7-bit ctrl and 3-bit cfg buses: the initiator side of that interface.
//  - Walks a feature map row by row and word by word.
//  - Issues pop/shift for horizontal windows and row-FIFO pop/push/mux for vertical windows.
//  - Sits between the layer scheduler (start/done) and the pooling datapath (ready in, ctrl/cfg out).
// PARAMETERS
//  NUM_PE      4  elements per input word
//  ROW_W       6  width of the cfg_rows row counter
//  WORD_W      5  width of the cfg_words words-per-row counter
//  COL_W       7  width of the cfg_out_cols output-column counter
//  TAP_LAT     2  cycles from tap cycle to aligned pooled value; sets push/mux/valid delay
// PORTS
//  clk         in   1       clock
//  reset       in   1       asynchronous, active-low reset
//  start       in   1       pulse; latches cfg_* when idle
//  cfg_k3      in   1       0 = 2x2 kernel, 1 = 3x3 kernel
//  cfg_stride  in   2       horizontal stride S, 1 or 2
//  cfg_rows    in   ROW_W   input rows H, excluding pad
//  cfg_words   in   WORD_W  words per input row
//  cfg_ocols   in   COL_W   output columns per row OW
//  cfg_pad     in   2       pad rows added top and bottom; used only with POOL_CTRL_PAD_EN
//  pool_ready  in   1       datapath input FIFO non-empty
//  ctrl        out  7       {pad_row, pool_valid, row_fifo_mux_sel, row_fifo_pop, row_fifo_push, pop, shift}
//  cfg         out  3       {kernel_size_switch, stride}
//  busy        out  1       high from accepted start until done
//  done        out  1       one-cycle pulse after the last ctrl bit has left the delay line
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, all counters 0. Reset mid-operation aborts immediately with no drain.
//  - IDLE: start latches cfg_*; busy=1 next cycle; cfg output = {cfg_k3, cfg_stride}, held until done.
//    start while busy is ignored.
//  - Per row, per word w: POP -> WAIT1 -> WAIT2 -> TAP.
//    - POP: pop=1 for one cycle when pool_ready=1; otherwise stall in POP. This is the only stall point.
//    - WAIT1/WAIT2: all ctrl bits 0 (shifter load latency).
//    - TAP: one cycle per output column, up to NUM_PE/S taps per word.
//      shift=1 on each tap except the last tap of the word; stop at OW taps for the row.
//  - Row end: after OW taps, go to POP of the next row; after the last row, go to DRAIN.
//    DRAIN waits TAP_LAT+1 cycles, then done=1 and busy=0.
//  - Vertical phase v = row mod K (K = 2 or 3); windows do not overlap vertically.
//    - v=0:       mux_sel=1, push=1, row_fifo_pop=0.
//    - 0<v<K-1:   mux_sel=0, row_fifo_pop=1, push=1.
//    - v=K-1:     mux_sel=0, row_fifo_pop=1, push=0, pool_valid=1.
//  - Timing for a tap at cycle t:
//    - row_fifo_pop at t+1.
//    - row_fifo_push, mux_sel and pool_valid at t+TAP_LAT.
//    - The delay line never stalls.
//  - Trailing rows (H mod K) are still popped and tapped, with push/row_fifo_pop/pool_valid forced 0.
//  - cfg_rows=0 or cfg_ocols=0: no ctrl activity; done one cycle after DRAIN entry.
// CONFIGURATION
//  POOL_CTRL_PAD_EN defined:
//    - cfg_pad zero rows are inserted before row 0 and after row H-1.
//    - Pad rows follow the same schedule with pad_row=1 alongside pop.
//    - POP does not wait for pool_ready on pad rows; pad rows count in v.
//  POOL_CTRL_PAD_EN undefined:
//    - cfg_pad is ignored and the pad_row bit is tied 0.
// STRUCTURE
//  Shared package pool_pkg:
//    - ctrl bit index localparams (PAD=6 .. SHIFT=0).
//    - FSM state enum {IDLE, POP, WAIT1, WAIT2, TAP, DRAIN}.
//    - kernel encoding constants.
//  Sub-module pool_ctrl_dly: TAP_LAT-deep shift register for {push, mux_sel, pool_valid} plus a 1-deep one for row_fifo_pop.
// TESTING
//  1. K=2, S=2, H=2, words=1, OW=2, pool_ready=1:
//     pop, 2 idle, 2 taps (shift only on first) per row.
//     Row0 push x2 with mux=1; row1 pool_valid x2; done 4 cycles after last tap.
//  2. K=3, S=1, H=3, words=2, OW=6:
//     row_fifo_pop at t+1, push at t+2 for row1; valid only on row2; 6 valid pulses total.
//  3. pool_ready=0 for 5 cycles at word 1 of row 0:
//     POP held, no ctrl bits during stall, taps resume unchanged; total pops = 2.
//  4. H=5, K=2: row 4 produces pops/shifts but no push, row_fifo_pop or pool_valid.
//  5. Reset asserted mid-TAP: ctrl, cfg, busy, done all 0 asynchronously; new start after release runs a clean layer.
//  6. POOL_CTRL_PAD_EN, cfg_pad=1, H=2, K=2:
//     rows 0 and 3 carry pad_row=1 with pool_ready held 0; only real rows wait for pool_ready.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared constants for the pooling sequencer: ctrl bit positions, FSM state codes
// and kernel encoding.
package pool_pkg;
    localparam int CTRL_PAD   = 6;
    localparam int CTRL_VALID = 5;
    localparam int CTRL_MUX   = 4;
    localparam int CTRL_RFPOP = 3;
    localparam int CTRL_PUSH  = 2;
    localparam int CTRL_POP   = 1;
    localparam int CTRL_SHIFT = 0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_POP   = 3'd1;
    localparam logic [2:0] ST_WAIT1 = 3'd2;
    localparam logic [2:0] ST_WAIT2 = 3'd3;
    localparam logic [2:0] ST_TAP   = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;

    localparam logic KERNEL_2X2 = 1'b0;
    localparam logic KERNEL_3X3 = 1'b1;

    function automatic logic [1:0] kernel_rows(input logic k3);
        return (k3 == KERNEL_3X3) ? 2'd3 : 2'd2;
    endfunction
endpackage

// File: rtl/pooling_ctrl_if.sv
// Scheduler/datapath bus of the pooling sequencer; master is the sequencer itself.
interface pooling_ctrl_if #(
    parameter int ROW_W  = 6,
    parameter int WORD_W = 5,
    parameter int COL_W  = 7
);
    logic              start;
    logic              cfg_k3;
    logic [1:0]        cfg_stride;
    logic [ROW_W-1:0]  cfg_rows;
    logic [WORD_W-1:0] cfg_words;
    logic [COL_W-1:0]  cfg_ocols;
    logic [1:0]        cfg_pad;
    logic              pool_ready;
    logic [6:0]        ctrl;
    logic [2:0]        cfg;
    logic              busy;
    logic              done;

    modport master (
        input  start, cfg_k3, cfg_stride, cfg_rows, cfg_words, cfg_ocols, cfg_pad, pool_ready,
        output ctrl, cfg, busy, done
    );
    modport slave (
        output start, cfg_k3, cfg_stride, cfg_rows, cfg_words, cfg_ocols, cfg_pad, pool_ready,
        input  ctrl, cfg, busy, done
    );
endinterface

// File: rtl/pool_ctrl_dly.sv
// Fixed-latency alignment of the vertical-window ctrl bits: {push, mux, valid}
// trail the tap by TAP_LAT cycles, row_fifo_pop by one. Never stalls.
module pool_ctrl_dly #(
    parameter int TAP_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic mux_i,
    input  logic valid_i,
    input  logic rfpop_i,
    output logic push_o,
    output logic mux_o,
    output logic valid_o,
    output logic rfpop_o
);
    logic [TAP_LAT-1:0][2:0] vld_pipe_q;
    logic                    rfpop_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe_q <= '0;
            rfpop_q    <= 1'b0;
        end else begin
            vld_pipe_q[0] <= {push_i, mux_i, valid_i};
            for (int i = 1; i < TAP_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
            rfpop_q <= rfpop_i;
        end
    end

    assign {push_o, mux_o, valid_o} = vld_pipe_q[TAP_LAT-1];
    assign rfpop_o = rfpop_q;
endmodule

// File: rtl/pooling_ctrl.sv
// Pooling sequencer: walks rows/words, emits pop/shift per tap and delayed
// row-FIFO ctrl. Optional pad rows under macro POOL_CTRL_PAD_EN.
module pooling_ctrl
    import pool_pkg::*;
#(
    parameter int NUM_PE  = 4,
    parameter int ROW_W   = 6,
    parameter int WORD_W  = 5,
    parameter int COL_W   = 7,
    parameter int TAP_LAT = 2
) (
    input logic            clk,
    input logic            reset,
    pooling_ctrl_if.master bus
);
    localparam int RW = ROW_W + 2;
    localparam int TW = $clog2(NUM_PE + 1);
    localparam int DW = $clog2(TAP_LAT + 1);

    logic [2:0]        state_q, state_d;
    logic              k3_q, k3_d, busy_q, busy_d, done_q, done_d;
    logic [1:0]        stride_q, stride_d, v_q, v_d;
    logic [ROW_W-1:0]  rows_q, rows_d;
    logic [WORD_W-1:0] words_q, words_d, w_q, w_d;
    logic [COL_W-1:0]  ocols_q, ocols_d, col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [TW-1:0]     tw_q, tw_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic [1:0]        pad_q, pad_d;

    logic [RW-1:0] total;
    logic [1:0]    kk;
    logic [TW-1:0] tpw;
    logic          trailing, is_pad, last_col, tap_last_word, last_word, row_end, last_row;
    logic          pop, shift, tap;
    logic          push_dly, mux_dly, valid_dly, rfpop_dly;

    assign kk  = kernel_rows(k3_q);
    assign tpw = (stride_q == 2'd2) ? TW'(NUM_PE / 2) : TW'(NUM_PE);

`ifdef POOL_CTRL_PAD_EN
    assign pad_d  = (state_q == ST_IDLE && bus.start) ? bus.cfg_pad : pad_q;
    assign total  = RW'(rows_q) + RW'({pad_q, 1'b0});
    assign is_pad = (row_q < RW'(pad_q)) || (row_q >= RW'(pad_q) + RW'(rows_q));
`else
    logic unused_pad;
    assign unused_pad = ^{bus.cfg_pad, pad_q};
    assign pad_d  = 2'd0;
    assign total  = RW'(rows_q);
    assign is_pad = 1'b0;
`endif

    // A row is trailing when its vertical group cannot be completed before the last row.
    assign trailing      = (row_q - RW'(v_q) + RW'(kk)) > total;
    assign last_col      = (col_q + COL_W'(1)) == ocols_q;
    assign tap_last_word = (tw_q + TW'(1)) == tpw;
    assign last_word     = (w_q + WORD_W'(1)) == words_q;
    assign row_end       = last_col || (tap_last_word && last_word);
    assign last_row      = (row_q + RW'(1)) == total;

    always_comb begin
        state_d  = state_q;
        k3_d     = k3_q;
        stride_d = stride_q;
        rows_d   = rows_q;
        words_d  = words_q;
        ocols_d  = ocols_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        row_d    = row_q;
        v_d      = v_q;
        w_d      = w_q;
        tw_d     = tw_q;
        col_d    = col_q;
        dcnt_d   = dcnt_q;
        pop      = 1'b0;
        shift    = 1'b0;
        tap      = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) begin
                k3_d     = bus.cfg_k3;
                stride_d = bus.cfg_stride;
                rows_d   = bus.cfg_rows;
                words_d  = bus.cfg_words;
                ocols_d  = bus.cfg_ocols;
                busy_d   = 1'b1;
                row_d    = '0;
                v_d      = '0;
                w_d      = '0;
                tw_d     = '0;
                col_d    = '0;
                // Empty layer: skip the drain wait, done follows one cycle later.
                if (bus.cfg_rows == '0 || bus.cfg_ocols == '0 || bus.cfg_words == '0) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = DW'(TAP_LAT);
                end else begin
                    state_d = ST_POP;
                    dcnt_d  = '0;
                end
            end
            ST_POP: if (bus.pool_ready || is_pad) begin
                pop     = 1'b1;
                state_d = ST_WAIT1;
            end
            ST_WAIT1: state_d = ST_WAIT2;
            ST_WAIT2: state_d = ST_TAP;
            ST_TAP: begin
                tap   = 1'b1;
                shift = !(tap_last_word || row_end);
                tw_d  = tw_q + TW'(1);
                col_d = col_q + COL_W'(1);
                if (row_end) begin
                    col_d = '0;
                    tw_d  = '0;
                    w_d   = '0;
                    if (last_row) begin
                        state_d = ST_DRAIN;
                        dcnt_d  = '0;
                    end else begin
                        state_d = ST_POP;
                        row_d   = row_q + RW'(1);
                        v_d     = ((v_q + 2'd1) == kk) ? 2'd0 : v_q + 2'd1;
                    end
                end else if (tap_last_word) begin
                    tw_d    = '0;
                    w_d     = w_q + WORD_W'(1);
                    state_d = ST_POP;
                end
            end
            ST_DRAIN: if (dcnt_q == DW'(TAP_LAT)) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            k3_q     <= 1'b0;
            stride_q <= '0;
            rows_q   <= '0;
            words_q  <= '0;
            ocols_q  <= '0;
            pad_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            row_q    <= '0;
            v_q      <= '0;
            w_q      <= '0;
            tw_q     <= '0;
            col_q    <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            k3_q     <= k3_d;
            stride_q <= stride_d;
            rows_q   <= rows_d;
            words_q  <= words_d;
            ocols_q  <= ocols_d;
            pad_q    <= pad_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            row_q    <= row_d;
            v_q      <= v_d;
            w_q      <= w_d;
            tw_q     <= tw_d;
            col_q    <= col_d;
            dcnt_q   <= dcnt_d;
        end
    end

    pool_ctrl_dly #(.TAP_LAT(TAP_LAT)) u_dly (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tap && !trailing && (v_q != kk - 2'd1)),
        .mux_i   (tap && (v_q == 2'd0)),
        .valid_i (tap && !trailing && (v_q == kk - 2'd1)),
        .rfpop_i (tap && !trailing && (v_q != 2'd0)),
        .push_o  (push_dly),
        .mux_o   (mux_dly),
        .valid_o (valid_dly),
        .rfpop_o (rfpop_dly)
    );

    assign bus.ctrl = {pop && is_pad, valid_dly, mux_dly, rfpop_dly, push_dly, pop, shift};
    assign bus.cfg  = busy_q ? {k3_q, stride_q} : 3'b000;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
